// File: rtl/pp_compressor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pp_compressor_pkg
//  Description : Shared constants for the partial-product compressor. These
//                cover the datapath width, the partial-product count that the
//                tree is built for, and the pipeline depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package pp_compressor_pkg;

    // Width of every partial product and of the final product.
    localparam int W          = 64;
    // Number of partial products. The reduction tree is wired for exactly 17.
    localparam int NPP        = 17;
    // Number of register stages between acceptance and valid_o.
    localparam int PIPE_DEPTH = 3;

endpackage : pp_compressor_pkg
`default_nettype wire

// File: rtl/pp_compressor_csa_3to2.sv
`default_nettype none
// ============================================================================
//  Module      : csa_3to2
//  Description : Purely combinational 3:2 carry-save counter.
//                The sum output is the bitwise XOR of the three inputs.
//                The carry output is the bitwise majority shifted left by one
//                position, so it can be added to the sum directly. The
//                majority bit at W-1 falls off the top, so the result wraps
//                modulo 2^W.
//  Ports       : i_a, i_b, i_c  [W-1:0]  operands
//                o_sum          [W-1:0]  bitwise sum
//                o_carry        [W-1:0]  carries, already weighted (<<1)
//  Revision    : 1.0 - initial release
// ============================================================================
module csa_3to2 #(
    parameter int W = pp_compressor_pkg::W
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_carry
);

    logic [W-1:0] w_maj;

    assign w_maj   = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    assign o_sum   = i_a ^ i_b ^ i_c;
    assign o_carry = {w_maj[W-2:0], 1'b0};

endmodule : csa_3to2
`default_nettype wire

// File: rtl/pp_compressor.sv
`default_nettype none
// ============================================================================
//  Module      : pp_compressor
//  Description : Reduces 17 pre-shifted, sign-extended partial products to a
//                single W-bit product using a three-stage pipeline:
//                  S1: CSA levels 17->12->8->6, register 6 vectors
//                  S2: CSA levels 6->4->3->2,   register sum/carry
//                  S3: carry-propagate add,      register product
//                The valid/ready handshake is used on both sides. Every stage
//                advances when it is empty or when the stage after it
//                advances, so bubbles are removed from the pipeline. When the
//                pipeline is full and ready_i=1, it still accepts one beat per
//                cycle.
//  Ports       : clk        clock
//                rst        synchronous active-high reset
//                valid_i    upstream beat valid
//                ready_o    a beat can be accepted this cycle
//                pp_i       flattened partial products, pp k at [k*W +: W]
//                valid_o    product_o holds a valid result
//                ready_i    downstream accepts product_o this cycle
//                product_o  sum of all partial products, mod 2^W
//  Revision    : 1.0 - initial release
// ============================================================================
module pp_compressor
    import pp_compressor_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [NPP*W-1:0]   pp_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [W-1:0]       product_o
);

    // ------------------------------------------------------------------------
    // Stage control. Index 0 is the first stage and index 2 is the output stage.
    // ------------------------------------------------------------------------
    logic [PIPE_DEPTH-1:0] r_valid;
    logic [PIPE_DEPTH-1:0] w_adv;

    // Each stage may advance if it is empty or if the next stage advances.
    assign w_adv[2] = ~r_valid[2] | ready_i;
    assign w_adv[1] = ~r_valid[1] | w_adv[2];
    assign w_adv[0] = ~r_valid[0] | w_adv[1];

    assign ready_o  = w_adv[0];
    assign valid_o  = r_valid[2];

    // ------------------------------------------------------------------------
    // Stage 1 tree: 17 -> 12 -> 8 -> 6
    // ------------------------------------------------------------------------
    logic [W-1:0] w_l0 [NPP];
    logic [W-1:0] w_l1 [12];
    logic [W-1:0] w_l2 [8];
    logic [W-1:0] w_l3 [6];

    for (genvar k = 0; k < NPP; k++) begin : g_unpack
        assign w_l0[k] = pp_i[k*W +: W];
    end

    // 17 -> 12: pp0..pp14 go through five CSAs, pp15 and pp16 pass through.
    for (genvar i = 0; i < 5; i++) begin : g_l1_csa
        csa_3to2 #(.W(W)) u_csa (
            .i_a     (w_l0[3*i]),
            .i_b     (w_l0[3*i+1]),
            .i_c     (w_l0[3*i+2]),
            .o_sum   (w_l1[2*i]),
            .o_carry (w_l1[2*i+1])
        );
    end
    assign w_l1[10] = w_l0[15];
    assign w_l1[11] = w_l0[16];

    // 12 -> 8: four CSAs consume all twelve vectors.
    for (genvar i = 0; i < 4; i++) begin : g_l2_csa
        csa_3to2 #(.W(W)) u_csa (
            .i_a     (w_l1[3*i]),
            .i_b     (w_l1[3*i+1]),
            .i_c     (w_l1[3*i+2]),
            .o_sum   (w_l2[2*i]),
            .o_carry (w_l2[2*i+1])
        );
    end

    // 8 -> 6: two CSAs, last two vectors pass through.
    for (genvar i = 0; i < 2; i++) begin : g_l3_csa
        csa_3to2 #(.W(W)) u_csa (
            .i_a     (w_l2[3*i]),
            .i_b     (w_l2[3*i+1]),
            .i_c     (w_l2[3*i+2]),
            .o_sum   (w_l3[2*i]),
            .o_carry (w_l3[2*i+1])
        );
    end
    assign w_l3[4] = w_l2[6];
    assign w_l3[5] = w_l2[7];

    // ------------------------------------------------------------------------
    // Stage 2 tree: 6 -> 4 -> 3 -> 2, fed from the stage-1 registers
    // ------------------------------------------------------------------------
    logic [W-1:0] r_s1 [6];
    logic [W-1:0] w_l4 [4];
    logic [W-1:0] w_l5 [3];
    logic [W-1:0] w_sum2;
    logic [W-1:0] w_cy2;

    for (genvar i = 0; i < 2; i++) begin : g_l4_csa
        csa_3to2 #(.W(W)) u_csa (
            .i_a     (r_s1[3*i]),
            .i_b     (r_s1[3*i+1]),
            .i_c     (r_s1[3*i+2]),
            .o_sum   (w_l4[2*i]),
            .o_carry (w_l4[2*i+1])
        );
    end

    // 4 -> 3: one CSA, the fourth vector passes through.
    csa_3to2 #(.W(W)) u_l5_csa (
        .i_a     (w_l4[0]),
        .i_b     (w_l4[1]),
        .i_c     (w_l4[2]),
        .o_sum   (w_l5[0]),
        .o_carry (w_l5[1])
    );
    assign w_l5[2] = w_l4[3];

    // 3 -> 2: final CSA that produces the redundant sum/carry pair.
    csa_3to2 #(.W(W)) u_l6_csa (
        .i_a     (w_l5[0]),
        .i_b     (w_l5[1]),
        .i_c     (w_l5[2]),
        .o_sum   (w_sum2),
        .o_carry (w_cy2)
    );

    // ------------------------------------------------------------------------
    // Pipeline registers. Each data register loads whenever its stage
    // advances. When the incoming valid is low the loaded value is garbage,
    // but it is never seen because the matching valid bit is also cleared.
    // ------------------------------------------------------------------------
    logic [W-1:0] r_sum2;
    logic [W-1:0] r_cy2;
    logic [W-1:0] r_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < 6; k++) begin
                r_s1[k] <= '0;
            end
            r_sum2  <= '0;
            r_cy2   <= '0;
            r_prod  <= '0;
        end else begin
            if (w_adv[0]) begin
                r_valid[0] <= valid_i;
                for (int k = 0; k < 6; k++) begin
                    r_s1[k] <= w_l3[k];
                end
            end
            if (w_adv[1]) begin
                r_valid[1] <= r_valid[0];
                r_sum2     <= w_sum2;
                r_cy2      <= w_cy2;
            end
            if (w_adv[2]) begin
                r_valid[2] <= r_valid[1];
                r_prod     <= r_sum2 + r_cy2;
            end
        end
    end

    assign product_o = r_prod;

endmodule : pp_compressor
`default_nettype wire

// File: tb/tb_pp_compressor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pp_compressor
//  Description : Self-checking bench for pp_compressor. Directed steps run in
//                a single initial block. When a beat is accepted, its expected
//                product goes into a queue. Each completed output handshake
//                pops the oldest entry and compares it with product_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pp_compressor;
    import pp_compressor_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               valid_i;
    logic               ready_o;
    logic [NPP*W-1:0]   pp_i;
    logic               valid_o;
    logic               ready_i;
    logic [W-1:0]       product_o;

    pp_compressor u_dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .pp_i      (pp_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .product_o (product_o)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    logic [W-1:0]  sb [$];
    int            cyc_n = 0;
    int            acc_cnt = 0;
    int            out_cnt = 0;
    int            first_out = -1;
    int            last_out  = -1;
    bit            last_acc  = 1'b0;
    bit            stall_prev = 1'b0;
    logic [W-1:0]  stall_prod = '0;
    logic [NPP*W-1:0] v;

    // Reference sum of all partial products, mod 2^W.
    function automatic logic [W-1:0] model_sum(input logic [NPP*W-1:0] x);
        logic [W-1:0] s;
        s = '0;
        for (int k = 0; k < NPP; k++) s += x[k*W +: W];
        return s;
    endfunction

    // Radix-4 Booth partial product k for signed 32x32 operands.
    function automatic logic [W-1:0] booth_pp(input logic signed [31:0] a,
                                              input logic signed [31:0] b,
                                              input int k);
        logic [34:0]         bx;
        logic [2:0]          t;
        int                  d;
        logic signed [63:0]  ax;
        logic signed [63:0]  dd;
        bx = {b[31], b[31], b, 1'b0};
        t  = {bx[2*k+2], bx[2*k+1], bx[2*k]};
        case (t)
            3'd1, 3'd2: d = 1;
            3'd3:       d = 2;
            3'd4:       d = -2;
            3'd5, 3'd6: d = -1;
            default:    d = 0;
        endcase
        ax = a;
        dd = d;
        return 64'(ax * dd) << (2 * k);
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: evaluate the handshakes with the inputs as currently driven,
    // update the scoreboard, then advance to 1ns after the next rising edge.
    task automatic cyc();
        bit fin;
        bit fout;
        #1;
        fin  = valid_i && ready_o && !rst;
        fout = valid_o && ready_i && !rst;
        if (!rst && stall_prev) begin
            chk("stall_valid", {63'd0, valid_o}, 64'd1);
            chk("stall_hold", product_o, stall_prod);
        end
        stall_prev = !rst && valid_o && !ready_i;
        stall_prod = product_o;
        if (fout) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL sb_unexpected observed=%h expected=none", product_o);
            end
            if (sb.size() != 0) chk("sb_data", product_o, sb.pop_front());
            out_cnt++;
            if (first_out < 0) first_out = cyc_n;
            last_out = cyc_n;
        end
        if (fin) begin
            sb.push_back(model_sum(pp_i));
            acc_cnt++;
        end
        last_acc = fin;
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // Offer beat x until it is accepted, giving up after budget cycles.
    task automatic send(input logic [NPP*W-1:0] x, input int budget);
        valid_i = 1'b1;
        pp_i    = x;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (last_acc) break;
        end
        total++;
        assert (last_acc) else begin
            bad++;
            $error("FAIL send_timeout observed=not_accepted expected=accepted");
        end
    endtask

    task automatic drain(input string tag);
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) cyc();
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [NPP*W-1:0]   bp [6];
        int                 idx;
        int                 acc0;
        int                 out0;
        logic signed [31:0] ta [3];
        logic signed [31:0] tb [3];
        logic signed [63:0] ea;
        logic signed [63:0] eb;

        // ---------------- reset ----------------
        rst = 1'b1; valid_i = 1'b1; ready_i = 1'b1;
        for (int k = 0; k < NPP; k++) pp_i[k*W +: W] = 64'h5;
        cyc();
        cyc();
        chk("rst_valid_o", {63'd0, valid_o}, 64'd0);
        chk("rst_product_o", product_o, 64'd0);
        chk("rst_ready_o", {63'd0, ready_o}, 64'd1);
        rst = 1'b0; valid_i = 1'b0;
        repeat (5) cyc();
        chk("no_out_after_reset", 64'(out_cnt), 64'd0);

        // ---------------- single beat, latency ----------------
        for (int k = 0; k < NPP; k++) v[k*W +: W] = 64'h1;
        send(v, 4);
        valid_i = 1'b0;
        chk("lat_c1_valid", {63'd0, valid_o}, 64'd0);
        cyc();
        chk("lat_c2_valid", {63'd0, valid_o}, 64'd0);
        cyc();
        chk("lat_c3_valid", {63'd0, valid_o}, 64'd1);
        chk("lat_c3_product", product_o, 64'd17);
        cyc();
        chk("lat_one_cycle", {63'd0, valid_o}, 64'd0);

        // ---------------- wrap / sign ----------------
        v = '0;
        v[0*W +: W] = 64'hFFFF_FFFF_FFFF_FFFF;
        v[1*W +: W] = 64'h1;
        send(v, 4);
        for (int k = 0; k < NPP; k++) v[k*W +: W] = 64'h8000_0000_0000_0000;
        send(v, 4);
        valid_i = 1'b0;
        cyc();
        chk("wrap_zero", product_o, 64'd0);
        cyc();
        chk("msb_sum", product_o, 64'h8000_0000_0000_0000);
        drain("wrap_drain");

        // ---------------- streaming ----------------
        out_cnt = 0; first_out = -1; last_out = -1;
        for (int n = 1; n <= 8; n++) begin
            v = '0;
            v[0 +: W] = 64'(n);
            send(v, 2);
        end
        drain("stream_drain");
        chk("stream_count", 64'(out_cnt), 64'd8);
        chk("stream_no_gap", 64'(last_out - first_out), 64'd7);

        // ---------------- backpressure ----------------
        for (int i = 0; i < 6; i++) begin
            bp[i] = '0;
            bp[i][0 +: W] = 64'(100 + i);
            bp[i][5*W +: W] = 64'(i * 3);
        end
        ready_i = 1'b0; valid_i = 1'b1; idx = 0; acc0 = acc_cnt;
        for (int i = 0; i < 6; i++) begin
            pp_i = bp[idx];
            cyc();
            if (last_acc) idx++;
        end
        chk("bp_accepted", 64'(acc_cnt - acc0), 64'd3);
        chk("bp_ready_low", {63'd0, ready_o}, 64'd0);
        chk("bp_valid_held", {63'd0, valid_o}, 64'd1);
        ready_i = 1'b1;
        while (idx < 6) begin
            send(bp[idx], 10);
            idx++;
        end
        drain("bp_drain");

        // ---------------- random ready_i toggling ----------------
        idx = 0;
        for (int k = 0; k < NPP; k++) v[k*W +: W] = {$urandom(), $urandom()};
        for (int c = 0; c < 20000 && idx < 1000; c++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 2) != 0);
            pp_i    = v;
            cyc();
            if (last_acc) begin
                idx++;
                for (int k = 0; k < NPP; k++) v[k*W +: W] = {$urandom(), $urandom()};
            end
        end
        chk("rand_beats", 64'(idx), 64'd1000);
        drain("rand_drain");

        // ---------------- end-to-end with Booth generator ----------------
        ta[0] = -32'sd3;     tb[0] = 32'sd7;
        ta[1] = 32'sd5;      tb[1] = -32'sd9;
        ta[2] = 32'sd123456; tb[2] = -32'sd654321;
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < NPP; k++) v[k*W +: W] = booth_pp(ta[t], tb[t], k);
            ea = ta[t];
            eb = tb[t];
            send(v, 4);
            valid_i = 1'b0;
            cyc();
            cyc();
            chk("booth_valid", {63'd0, valid_o}, 64'd1);
            chk("booth_product", product_o, 64'(ea * eb));
            cyc();
        end
        chk("booth_m3x7", 64'(-64'sd3 * 64'sd7), 64'hFFFF_FFFF_FFFF_FFEB);

        // ---------------- reset with beats in flight ----------------
        for (int k = 0; k < NPP; k++) v[k*W +: W] = 64'h2;
        send(v, 4);
        send(v, 4);
        valid_i = 1'b0;
        rst = 1'b1;
        cyc();
        sb.delete();
        rst = 1'b0;
        out0 = out_cnt;
        repeat (8) cyc();
        chk("rst_flight_no_out", 64'(out_cnt - out0), 64'd0);
        chk("rst_flight_valid", {63'd0, valid_o}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pp_compressor
`default_nettype wire
